// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC and IF/ID register owner; in: clk rst stall_f stall_d flush_d pc_src_e pc_target_e instr_f; out: pc_f instr_d pc_d pc_plus4_d valid_d fault fault_pc fetch_count bubble_count
module fetch_stage_ctrl #(
  parameter int WIDTH = 32,
  parameter int A_WIDTH = 12,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             pc_src_e,
  input  logic [WIDTH-1:0] pc_target_e,
  input  logic [WIDTH-1:0] instr_f,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             valid_d,
  output logic             fault,
  output logic [WIDTH-1:0] fault_pc,
  output logic [31:0]      fetch_count,
  output logic [31:0]      bubble_count
);
  localparam logic [WIDTH-1:0] ROM_LAST = WIDTH'((64'd1 << A_WIDTH) - 64'd4);
  logic [WIDTH-1:0] pc_plus4_f;
  logic bad_f, kill, bubble, capture, set_fault;
  always_comb begin
    pc_plus4_f = pc_f + WIDTH'(4);
    bad_f = (pc_f[1:0] != 2'b00) || (pc_f > ROM_LAST);
    kill = flush_d || pc_src_e;
    bubble = kill || (!stall_d && bad_f);
    capture = !bubble && !stall_d;
    set_fault = !kill && !stall_d && bad_f && !fault;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f <= RESET_PC;
      instr_d <= NOP_INSTR;
      pc_d <= '0;
      pc_plus4_d <= '0;
      valid_d <= 1'b0;
      fault <= 1'b0;
      fault_pc <= '0;
      fetch_count <= '0;
      bubble_count <= '0;
    end else begin
      pc_f <= pc_src_e ? pc_target_e : stall_f ? pc_f : pc_plus4_f;
      if (bubble) begin
        instr_d <= NOP_INSTR;
        pc_d <= '0;
        pc_plus4_d <= '0;
        valid_d <= 1'b0;
        bubble_count <= bubble_count + 32'd1;
      end else if (capture) begin
        instr_d <= instr_f;
        pc_d <= pc_f;
        pc_plus4_d <= pc_plus4_f;
        valid_d <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
      if (set_fault) begin
        fault <= 1'b1;
        fault_pc <= pc_f;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb_fetch_stage_ctrl: directed self-checking bench for fetch_stage_ctrl
module tb_fetch_stage_ctrl;
  logic clk = 0, rst = 0, stall_f = 0, stall_d = 0, flush_d = 0, pc_src_e = 0;
  logic [31:0] pc_target_e = 0, instr_f, pc_f, instr_d, pc_d, pc_plus4_d, fault_pc, fetch_count, bubble_count;
  logic valid_d, fault;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign instr_f = {16'hC0DE, pc_f[15:0]};
  fetch_stage_ctrl dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .instr_f(instr_f), .pc_f(pc_f),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count), .bubble_count(bubble_count)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
    tick();
    rst = 0;
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (pc_f !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_f); end
    total++; if (instr_d !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h exp=13", instr_d); end
    total++; if ({valid_d, fault} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {valid_d, fault}); end
    total++; if ({pc_d, pc_plus4_d, fault_pc, fetch_count, bubble_count} !== 160'h0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {pc_d, pc_plus4_d, fault_pc, fetch_count, bubble_count}); end
  endtask
  task automatic test_free_run();
    logic [31:0] exp_pc [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (pc_f !== exp_pc[i]) begin bad++; $display("FAIL free_pc%0d got=%h exp=%h", i, pc_f, exp_pc[i]); end
    end
    total++; if (instr_d !== 32'hC0DE000C) begin bad++; $display("FAIL free_instr got=%h exp=C0DE000C", instr_d); end
    total++; if (pc_d !== 32'hC || pc_plus4_d !== 32'h10) begin bad++; $display("FAIL free_pcd got=%h/%h exp=C/10", pc_d, pc_plus4_d); end
    total++; if (valid_d !== 1'b1 || fetch_count !== 32'd4) begin bad++; $display("FAIL free_cnt got=%b/%0d exp=1/4", valid_d, fetch_count); end
  endtask
  task automatic test_stall();
    do_reset();
    tick(); tick();
    stall_f = 1; stall_d = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (pc_f !== 32'h8 || instr_d !== 32'hC0DE0004 || pc_d !== 32'h4) begin bad++; $display("FAIL stall_hold%0d got=%h/%h/%h exp=8/C0DE0004/4", i, pc_f, instr_d, pc_d); end
    end
    stall_f = 0; stall_d = 0;
    tick();
    total++; if (pc_f !== 32'hC || instr_d !== 32'hC0DE0008 || pc_d !== 32'h8) begin bad++; $display("FAIL stall_release got=%h/%h/%h exp=C/C0DE0008/8", pc_f, instr_d, pc_d); end
    total++; if (fetch_count !== 32'd3 || bubble_count !== 32'd0) begin bad++; $display("FAIL stall_cnt got=%0d/%0d exp=3/0", fetch_count, bubble_count); end
  endtask
  task automatic test_redirect();
    tick();
    total++; if (pc_f !== 32'h10) begin bad++; $display("FAIL redir_pre got=%h exp=10", pc_f); end
    pc_src_e = 1; pc_target_e = 32'h40; stall_f = 1;
    tick();
    pc_src_e = 0; stall_f = 0;
    total++; if (pc_f !== 32'h40 || valid_d !== 1'b0 || instr_d !== 32'h13 || pc_d !== 32'h0) begin bad++; $display("FAIL redir_bubble got=%h/%b/%h/%h exp=40/0/13/0", pc_f, valid_d, instr_d, pc_d); end
    total++; if (bubble_count !== 32'd1) begin bad++; $display("FAIL redir_bcnt got=%0d exp=1", bubble_count); end
    tick();
    total++; if (instr_d !== 32'hC0DE0040 || pc_d !== 32'h40 || pc_plus4_d !== 32'h44 || valid_d !== 1'b1) begin bad++; $display("FAIL redir_cap got=%h/%h/%h/%b exp=C0DE0040/40/44/1", instr_d, pc_d, pc_plus4_d, valid_d); end
    total++; if (pc_f !== 32'h44 || fetch_count !== 32'd5) begin bad++; $display("FAIL redir_next got=%h/%0d exp=44/5", pc_f, fetch_count); end
  endtask
  task automatic test_rom_end();
    pc_src_e = 1; pc_target_e = 32'hFFC;
    tick();
    pc_src_e = 0;
    tick();
    total++; if (valid_d !== 1'b1 || pc_d !== 32'hFFC || fault !== 1'b0 || fetch_count !== 32'd6) begin bad++; $display("FAIL rom_end got=%b/%h/%b/%0d exp=1/FFC/0/6", valid_d, pc_d, fault, fetch_count); end
    total++; if (bubble_count !== 32'd2) begin bad++; $display("FAIL rom_end_bcnt got=%0d exp=2", bubble_count); end
  endtask
  task automatic test_fault();
    pc_src_e = 1; pc_target_e = 32'h102;
    tick();
    pc_src_e = 0;
    total++; if (pc_f !== 32'h102 || valid_d !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL fault_redir got=%h/%b/%b exp=102/0/0", pc_f, valid_d, fault); end
    tick();
    total++; if (fault !== 1'b1 || fault_pc !== 32'h102 || valid_d !== 1'b0 || instr_d !== 32'h13) begin bad++; $display("FAIL fault_set got=%b/%h/%b/%h exp=1/102/0/13", fault, fault_pc, valid_d, instr_d); end
    total++; if (pc_f !== 32'h106 || bubble_count !== 32'd4) begin bad++; $display("FAIL fault_adv got=%h/%0d exp=106/4", pc_f, bubble_count); end
    pc_src_e = 1; pc_target_e = 32'h1000;
    tick();
    pc_src_e = 0;
    tick();
    total++; if (fault !== 1'b1 || fault_pc !== 32'h102 || valid_d !== 1'b0) begin bad++; $display("FAIL fault_sticky got=%b/%h/%b exp=1/102/0", fault, fault_pc, valid_d); end
    total++; if (pc_f !== 32'h1004 || bubble_count !== 32'd6 || fetch_count !== 32'd6) begin bad++; $display("FAIL fault_cnt got=%h/%0d/%0d exp=1004/6/6", pc_f, bubble_count, fetch_count); end
  endtask
  task automatic test_reset_mid();
    stall_f = 1; stall_d = 1; pc_src_e = 1; pc_target_e = 32'h80; rst = 1;
    tick();
    rst = 0; stall_f = 0; stall_d = 0; pc_src_e = 0;
    total++; if (pc_f !== 32'h0 || instr_d !== 32'h13 || valid_d !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL rstmid_a got=%h/%h/%b/%b exp=0/13/0/0", pc_f, instr_d, valid_d, fault); end
    total++; if ({pc_d, pc_plus4_d, fault_pc, fetch_count, bubble_count} !== 160'h0) begin bad++; $display("FAIL rstmid_b got=%h exp=0", {pc_d, pc_plus4_d, fault_pc, fetch_count, bubble_count}); end
  endtask
  task automatic test_flush_stall();
    tick();
    flush_d = 1; stall_d = 1;
    tick();
    flush_d = 0; stall_d = 0;
    total++; if (valid_d !== 1'b0 || instr_d !== 32'h13 || pc_d !== 32'h0 || pc_plus4_d !== 32'h0) begin bad++; $display("FAIL flush_bubble got=%b/%h/%h/%h exp=0/13/0/0", valid_d, instr_d, pc_d, pc_plus4_d); end
    total++; if (bubble_count !== 32'd1 || fetch_count !== 32'd1 || pc_f !== 32'h8) begin bad++; $display("FAIL flush_cnt got=%0d/%0d/%h exp=1/1/8", bubble_count, fetch_count, pc_f); end
  endtask
  task automatic test_wrap();
    pc_src_e = 1; pc_target_e = 32'hFFFF_FFFC;
    tick();
    pc_src_e = 0;
    tick();
    total++; if (pc_f !== 32'h0 || fault !== 1'b1 || fault_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap got=%h/%b/%h exp=0/1/FFFFFFFC", pc_f, fault, fault_pc); end
  endtask
  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_rom_end();
    test_fault();
    test_reset_mid();
    test_flush_stall();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
- Fetch-stage controller that owns the program counter and the IF/ID pipeline register.
- It drives the byte address into the combinational instruction memory and captures the returned 32-bit word, together with its PC and PC+4, into the decode-stage register.
- It applies redirects, stalls and flushes from the hazard unit and EX stage.
- It flags fetches outside the instruction ROM window or misaligned fetches, and keeps fetch and bubble counters for debug.

Parameters:
- WIDTH, 32, width of PC, instruction and target buses
- A_WIDTH, 12, instruction ROM address bits; legal byte range 0x000 to 2**A_WIDTH-1
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, word inserted into IF/ID as a bubble (addi x0,x0,0)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall_f  in  1  hold PC this cycle
- stall_d  in  1  hold IF/ID register this cycle
- flush_d  in  1  load bubble into IF/ID this cycle
- pc_src_e  in  1  EX-stage redirect (taken branch/jump)
- pc_target_e  in  WIDTH  redirect target byte address
- instr_f  in  WIDTH  instruction word read from instruction memory at pc_f
- pc_f  out  WIDTH  current fetch address, to instruction memory
- instr_d  out  WIDTH  IF/ID instruction
- pc_d  out  WIDTH  IF/ID PC
- pc_plus4_d  out  WIDTH  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction
- fault  out  1  sticky fetch fault
- fault_pc  out  WIDTH  PC of first faulting fetch
- fetch_count  out  32  real instructions loaded into IF/ID
- bubble_count  out  32  bubbles loaded into IF/ID

Behaviour:
- All state updates on the rising edge of clk only; rst is sampled synchronously.
- Reset values (rst high at an edge):
  - pc_f=RESET_PC
  - instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0
  - fault=0, fault_pc=0, fetch_count=0, bubble_count=0
- rst overrides every other input, including mid-stall or mid-redirect; nothing pending survives reset.
- Fetch latency:
  - instr_f is combinational from pc_f.
  - The word at pc_f appears on instr_d one edge later.
  - The first instruction after rst deasserts is in IF/ID after the first non-reset edge.
- PC update priority (rst low):
  1. pc_src_e=1: pc_f<=pc_target_e.
  2. Else stall_f=1: pc_f holds.
  3. Else pc_f<=pc_f+4, modulo 2**WIDTH wrap.
- Redirect beats stall_f.
- bad_f, combinational:
  - true when pc_f[1:0]!=0, or when pc_f > 2**A_WIDTH-4 (the word would span past the ROM end or lie outside it).
  - pc_target_e is not realigned; a misaligned target surfaces as bad_f on the next cycle.
- IF/ID update priority (rst low):
  1. flush_d=1 or pc_src_e=1: bubble. instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, bubble_count+1.
  2. Else stall_d=1: all IF/ID outputs hold; no counter change.
  3. Else if bad_f: bubble as in step 1 (bubble_count+1). If fault=0, set fault=1 and fault_pc=pc_f.
  4. Else capture: instr_d=instr_f, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1, fetch_count+1.
- fault is sticky: once set it holds until rst, and fault_pc never updates again. PC advance is not blocked by fault.
- Counters wrap at 2**32 with no saturation.
- Simultaneous-input cases:
  - stall_f=1 and stall_d=0: legal. The same word is re-captured each edge; the hazard unit is responsible for avoiding this.
  - stall_f=0 and stall_d=1: the captured fetch is lost; this is legal but is the hazard unit's concern.
- No internal FSM beyond the register priorities above; the design is fully synchronous with no latches.

Test Plan:
- Reset then 4 free edges with ROM words W0..W3 at 0x0,0x4,0x8,0xC → pc_f sequence 0x4,0x8,0xC,0x10. On the 4th edge instr_d=W3, pc_d=0xC, pc_plus4_d=0x10, valid_d=1, fetch_count=4.
- At pc_f=0x8, assert stall_f and stall_d for 2 edges → pc_f stays 0x8 and instr_d/pc_d unchanged. When released, the next edge captures the 0x8 word and pc_f=0xC.
- At pc_f=0x10, pulse pc_src_e=1 with pc_target_e=0x40 and stall_f=1 → next edge pc_f=0x40, valid_d=0, instr_d=0x00000013, bubble_count+1. The following edge captures the word at 0x40 with pc_d=0x40.
- Redirect to 0x102 → next edge valid_d=0 and fault=1 with fault_pc=0x102. A later fault at pc_f=0x1000 leaves fault_pc=0x102.
- Assert rst during a stall with fault=1 and counters nonzero → after the edge all outputs are at reset values and pc_f=RESET_PC.
- Assert flush_d and stall_d together → bubble loaded (flush wins) and bubble_count increments by exactly 1.
